// File: rtl/debounce_pkg.sv
// Shared constants and sizing helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int DB_DEFAULT_PRESCALE = 50000;
  localparam int DB_DEFAULT_STABLE   = 8;

  // Bit width able to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: synchroniser, polarity normalisation, agreement counter,
// debounced state flop and registered press/release pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DB_DEFAULT_STABLE,
  parameter int ACTIVE_LOW   = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic debounced,
  output logic press,
  output logic release_pulse
);

  localparam int            CW         = clog2_min1(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);
  localparam logic          IDLE_LEVEL = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      if (s == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = s;
        cnt_d   = '0;
        press_d = s;
        rel_d   = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser presets to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign debounced     = state_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button/switch debouncer sharing one sample-tick prescaler.
// The release-pulse port is named release_pulse because "release" is a reserved word.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int PRESCALE     = DB_DEFAULT_PRESCALE,
  parameter int STABLE_COUNT = DB_DEFAULT_STABLE,
  parameter int ACTIVE_LOW   = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                sample_tk
);

  localparam int            PW       = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (pre_q == PRE_LAST);
    pre_d  = tick_d ? '0 : pre_q + PW'(1);
  end

  // Tick is registered so it is low in reset and glitch-free for every lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tk = tick_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debounce_channel #(
      .STABLE_COUNT (STABLE_COUNT),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick_q),
      .raw           (noisy[gi]),
      .debounced     (debounced[gi]),
      .press         (press[gi]),
      .release_pulse (release_pulse[gi])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: main instance (PRESCALE=4) plus a
// PRESCALE=1 active-high instance.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] noisy, debounced, press, release_pulse;
  logic       sample_tk;
  logic [3:0] noisy2, debounced2, press2, release2;
  logic       sample_tk2;

  int checks = 0;
  int errors = 0;
  int press_cnt [4];
  int rel_cnt   [4];

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS(4), .PRESCALE(4), .STABLE_COUNT(3), .ACTIVE_LOW(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .noisy(noisy), .debounced(debounced),
    .press(press), .release_pulse(release_pulse), .sample_tk(sample_tk)
  );

  multi_debouncer #(
    .CHANNELS(4), .PRESCALE(1), .STABLE_COUNT(3), .ACTIVE_LOW(0), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .noisy(noisy2), .debounced(debounced2),
    .press(press2), .release_pulse(release2), .sample_tk(sample_tk2)
  );

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (press[i] === 1'b1) press_cnt[i]++;
      if (release_pulse[i] === 1'b1) rel_cnt[i]++;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  task automatic wait_tick(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (sample_tk === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle_released();
    noisy = 4'hF;
    repeat (24) step();
    checks++;
    if (debounced !== 4'h0) begin
      errors++;
      $display("FAIL settle_released: debounced=%b expected=0000", debounced);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; noisy = 4'h0; noisy2 = 4'h0;
    repeat (3) step();
    checks++;
    if ({debounced, press, release_pulse, sample_tk} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: deb=%b press=%b rel=%b tk=%b expected all 0",
               debounced, press, release_pulse, sample_tk);
    end
    checks++;
    if ({debounced2, press2, release2, sample_tk2} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs2: deb=%b press=%b rel=%b tk=%b expected all 0",
               debounced2, press2, release2, sample_tk2);
    end
    rst = 1'b0;
    clear_counts();
    repeat (12) step();
    checks++;
    if (debounced !== 4'h0) begin
      errors++;
      $display("FAIL reset_early: debounced=%b expected=0000 after 12 clks", debounced);
    end
    step();
    checks++;
    if (debounced !== 4'hF || press !== 4'hF) begin
      errors++;
      $display("FAIL reset_flip: debounced=%b press=%b expected 1111/1111 at clk 13",
               debounced, press);
    end
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (press_cnt[i] != 1 || rel_cnt[i] != 0) begin
        errors++;
        $display("FAIL reset_pulses ch%0d: press=%0d release=%0d expected 1/0",
                 i, press_cnt[i], rel_cnt[i]);
      end
    end
    $display("test_reset done: debounced=%b", debounced);
  endtask

  task automatic test_clean_press();
    int  elapsed;
    bit  found;
    settle_released();
    clear_counts();
    noisy[0] = 1'b0;
    found = 1'b0;
    elapsed = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (debounced[0] === 1'b1) begin
        found = 1'b1;
        elapsed = n;
        break;
      end
    end
    checks++;
    if (!found || elapsed < 9 || elapsed > 17 || press[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_latency: found=%0d clks=%0d press0=%b expected 9..17 with press",
               found, elapsed, press[0]);
    end
    repeat (6) step();
    checks++;
    if (press_cnt[0] != 1 || rel_cnt[0] != 0) begin
      errors++;
      $display("FAIL clean_pulses: press=%0d release=%0d expected 1/0",
               press_cnt[0], rel_cnt[0]);
    end
    checks++;
    if (debounced !== 4'b0001 || press_cnt[1] + press_cnt[2] + press_cnt[3] != 0) begin
      errors++;
      $display("FAIL clean_others: debounced=%b other_presses=%0d expected 0001/0",
               debounced, press_cnt[1] + press_cnt[2] + press_cnt[3]);
    end
    $display("test_clean_press done: latency=%0d clks", elapsed);
  endtask

  task automatic test_bounce();
    bit seen;
    bit all_seen;
    int ticks;
    bit found;
    clear_counts();
    all_seen = 1'b1;
    wait_tick(seen);
    all_seen &= seen;
    for (int k = 0; k < 10; k++) begin
      noisy[1] = ~noisy[1];
      wait_tick(seen);
      all_seen &= seen;
    end
    checks++;
    if (!all_seen || debounced[1] !== 1'b0 || press_cnt[1] != 0) begin
      errors++;
      $display("FAIL bounce_hold_off: ticks_ok=%0d deb1=%b presses=%0d expected 1/0/0",
               all_seen, debounced[1], press_cnt[1]);
    end
    noisy[1] = 1'b0;
    ticks = 0;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (debounced[1] === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (sample_tk === 1'b1) ticks++;
    end
    checks++;
    if (!found || ticks != 3 || press[1] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settle: found=%0d ticks=%0d press1=%b expected 1/3/1",
               found, ticks, press[1]);
    end
    $display("test_bounce done: ticks to settle=%0d", ticks);
  endtask

  task automatic test_simultaneous();
    bit found;
    noisy[3] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (debounced[3] === 1'b1) break;
    end
    repeat (4) step();
    checks++;
    if (debounced[3] !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: deb3=%b expected 1", debounced[3]);
    end
    clear_counts();
    noisy[2] = 1'b0;
    noisy[3] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (press[2] === 1'b1 || release_pulse[3] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || press[2] !== 1'b1 || release_pulse[3] !== 1'b1 || debounced[3:2] !== 2'b01) begin
      errors++;
      $display("FAIL simul_pulses: press2=%b rel3=%b deb[3:2]=%b expected 1/1/01",
               press[2], release_pulse[3], debounced[3:2]);
    end
    $display("test_simultaneous done: debounced=%b", debounced);
  endtask

  task automatic test_reset_mid_window();
    bit seen;
    bit found;
    settle_released();
    clear_counts();
    wait_tick(seen);
    noisy[0] = 1'b0;
    wait_tick(seen);
    wait_tick(seen);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (debounced !== 4'h0 || press !== 4'h0 || release_pulse !== 4'h0) begin
      errors++;
      $display("FAIL midrst_async: deb=%b press=%b rel=%b expected 0000",
               debounced, press, release_pulse);
    end
    step();
    rst = 1'b0;
    clear_counts();
    repeat (10) step();
    checks++;
    if (press_cnt[0] != 0 || debounced[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_pulse: presses=%0d deb0=%b expected 0/0",
               press_cnt[0], debounced[0]);
    end
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (debounced[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || press_cnt[0] != 1) begin
      errors++;
      $display("FAIL midrst_fresh: found=%0d presses=%0d expected 1/1", found, press_cnt[0]);
    end
    $display("test_reset_mid_window done: debounced=%b", debounced);
  endtask

  task automatic test_prescale1();
    noisy2[0] = 1'b1;
    repeat (4) step();
    checks++;
    if (debounced2[0] !== 1'b0 || sample_tk2 !== 1'b1) begin
      errors++;
      $display("FAIL ps1_early: deb=%b tk=%b expected 0/1", debounced2[0], sample_tk2);
    end
    step();
    checks++;
    if (debounced2[0] !== 1'b1 || press2[0] !== 1'b1 || release2[0] !== 1'b0) begin
      errors++;
      $display("FAIL ps1_flip: deb=%b press=%b rel=%b expected 1/1/0",
               debounced2[0], press2[0], release2[0]);
    end
    step();
    checks++;
    if (debounced2[0] !== 1'b1 || press2[0] !== 1'b0) begin
      errors++;
      $display("FAIL ps1_pulse_width: deb=%b press=%b expected 1/0",
               debounced2[0], press2[0]);
    end
    $display("test_prescale1 done: debounced2=%b", debounced2);
  endtask

  initial begin
    rst = 1'b1;
    noisy = 4'hF;
    noisy2 = 4'h0;
    clear_counts();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_window();
    test_prescale1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
